// File: rtl/game_pkg.sv
// Shared definitions for the symbol-counting game.
// Phase encoding and default widths.
package game_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_PRE  = 3'd1,
    PH_PLAY = 3'd2,
    PH_POST = 3'd3,
    PH_WIN  = 3'd4,
    PH_OVER = 3'd5
  } phase_e;

  localparam int LEVEL_W_DEF = 3;
  localparam int TIME_W_DEF  = 6;

endpackage

// File: rtl/sec_down_counter.sv
// Loadable seconds down-counter shared by all timed phases.
// expire flags a tick arriving while the count sits at 1.
module sec_down_counter
  import game_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              Clk100M,
  input  logic              RstN,
  input  logic              load,
  input  logic [TIME_W-1:0] loadVal,
  input  logic              tick,
  output logic [TIME_W-1:0] count,
  output logic              expire
);

  assign expire = tick && (count == TIME_W'(1));

  // load wins; otherwise count ticks down, parking at zero
  always_ff @(posedge Clk100M or negedge RstN) begin
    if (!RstN) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (tick && count != '0) begin
      count <= count - TIME_W'(1);
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Round controller: countdown, play window, post period per level.
// Advances levels, ends the game on timeout or after the last level.
module level_sequencer
  import game_pkg::*;
#(
  parameter int PRE_SECONDS  = 3,
  parameter int PLAY_SECONDS = 30,
  parameter int POST_WAIT    = 10,
  parameter int NUM_LEVELS   = 8,
  parameter int LEVEL_W      = LEVEL_W_DEF,
  parameter int TIME_W       = TIME_W_DEF
) (
  input  logic               Clk100M,
  input  logic               RstN,
  input  logic               tick1Hz,
  input  logic               start,
  input  logic               abort,
  input  logic               answerCorrect,
  input  logic               levelComplete,
  output logic               genEnable,
  output logic               postSig,
  output logic [2:0]         phase,
  output logic [LEVEL_W-1:0] level,
  output logic [TIME_W-1:0]  secondsLeft,
  output logic               gameOver,
  output logic               gameWon
);

  localparam logic [LEVEL_W-1:0] LAST_LVL =
    LEVEL_W'(NUM_LEVELS - 1);

  phase_e             state;
  phase_e             nxt;
  logic [LEVEL_W-1:0] lvlNxt;
  logic               ld;
  logic [TIME_W-1:0]  ldVal;
  logic               expire;

  sec_down_counter #(
    .TIME_W (TIME_W)
  ) u_cnt (
    .Clk100M (Clk100M),
    .RstN    (RstN),
    .load    (ld),
    .loadVal (ldVal),
    .tick    (tick1Hz),
    .count   (secondsLeft),
    .expire  (expire)
  );

  assign phase = state;

  // state, level and registered phase flags
  always_ff @(posedge Clk100M or negedge RstN) begin
    if (!RstN) begin
      state     <= PH_IDLE;
      level     <= '0;
      genEnable <= 1'b0;
      postSig   <= 1'b0;
      gameOver  <= 1'b0;
      gameWon   <= 1'b0;
    end else begin
      state     <= nxt;
      level     <= lvlNxt;
      genEnable <= (nxt == PH_PLAY);
      postSig   <= (state == PH_PLAY)
                && (nxt == PH_POST);
      gameOver  <= (nxt == PH_OVER);
      gameWon   <= (nxt == PH_WIN);
    end
  end

  // next state, level and counter reload on every entry
  always_comb begin
    nxt    = state;
    lvlNxt = level;
    ld     = 1'b0;
    ldVal  = '0;
    case (state)
      PH_IDLE: begin
        lvlNxt = '0;
        if (start && !abort) nxt = PH_PRE;
      end
      PH_PRE: begin
        if (abort)       nxt = PH_IDLE;
        else if (expire) nxt = PH_PLAY;
      end
      PH_PLAY: begin
        if (abort)              nxt = PH_IDLE;
        else if (answerCorrect) nxt = PH_POST;
        else if (expire)        nxt = PH_OVER;
      end
      PH_POST: begin
        if (abort) begin
          nxt = PH_IDLE;
        end else if (levelComplete) begin
          if (level == LAST_LVL) begin
            nxt = PH_WIN;
          end else begin
            nxt    = PH_PRE;
            lvlNxt = level + LEVEL_W'(1);
          end
        end else if (expire) begin
          nxt = PH_OVER;
        end
      end
      PH_WIN, PH_OVER: begin
        if (abort) begin
          nxt = PH_IDLE;
        end else if (start) begin
          nxt    = PH_PRE;
          lvlNxt = '0;
        end
      end
      default: nxt = PH_IDLE;
    endcase
    if (nxt == PH_IDLE) lvlNxt = '0;
    if (nxt != state) begin
      ld = 1'b1;
      case (nxt)
        PH_PRE:  ldVal = TIME_W'(PRE_SECONDS);
        PH_PLAY: ldVal = TIME_W'(PLAY_SECONDS);
        PH_POST: ldVal = TIME_W'(POST_WAIT);
        default: ldVal = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer.
// Hand-computed expectations for default parameters.
module tb_level_sequencer;
  import game_pkg::*;

  logic       Clk100M = 1'b0;
  logic       RstN;
  logic       tick1Hz, start, abort;
  logic       answerCorrect, levelComplete;
  logic       genEnable, postSig, gameOver, gameWon;
  logic [2:0] phase;
  logic [2:0] level;
  logic [5:0] secondsLeft;

  int nCmp = 0;
  int nBad = 0;

  level_sequencer dut (
    .Clk100M       (Clk100M),
    .RstN          (RstN),
    .tick1Hz       (tick1Hz),
    .start         (start),
    .abort         (abort),
    .answerCorrect (answerCorrect),
    .levelComplete (levelComplete),
    .genEnable     (genEnable),
    .postSig       (postSig),
    .phase         (phase),
    .level         (level),
    .secondsLeft   (secondsLeft),
    .gameOver      (gameOver),
    .gameWon       (gameWon)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic chk(input string tag,
                     input int obs, input int exp);
    nCmp++;
    if (obs != exp) begin
      nBad++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic drive(input logic t, input logic s,
                       input logic ab, input logic ac,
                       input logic lc);
    @(negedge Clk100M);
    tick1Hz       = t;
    start         = s;
    abort         = ab;
    answerCorrect = ac;
    levelComplete = lc;
    @(posedge Clk100M);
    #1;
    tick1Hz       = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    answerCorrect = 1'b0;
    levelComplete = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
  endtask

  initial begin
    RstN = 1'b0;
    tick1Hz = 0; start = 0; abort = 0;
    answerCorrect = 0; levelComplete = 0;
    repeat (3) @(posedge Clk100M);
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_level", level, 0);
    chk("rst_secs", secondsLeft, 0);
    chk("rst_gen", genEnable, 0);
    chk("rst_post", postSig, 0);
    chk("rst_over", gameOver, 0);
    chk("rst_won", gameWon, 0);
    @(negedge Clk100M);
    RstN = 1'b1;

    // start and countdown
    drive(0, 1, 0, 0, 0);
    chk("pre_phase", phase, 1);
    chk("pre_s3", secondsLeft, 3);
    chk("pre_gen", genEnable, 0);
    ticks(1);
    chk("pre_s2", secondsLeft, 2);
    ticks(1);
    chk("pre_s1", secondsLeft, 1);
    ticks(1);
    chk("play_phase", phase, 2);
    chk("play_s30", secondsLeft, 30);
    chk("play_gen", genEnable, 1);

    // answer at 17 seconds left
    ticks(13);
    chk("play_s17", secondsLeft, 17);
    drive(0, 0, 0, 1, 0);
    chk("post_phase", phase, 3);
    chk("post_sig", postSig, 1);
    chk("post_gen", genEnable, 0);
    chk("post_s10", secondsLeft, 10);
    drive(0, 0, 0, 1, 0);
    chk("post_sig_once", postSig, 0);
    drive(0, 1, 0, 0, 0);
    chk("post_start_ign", phase, 3);
    drive(0, 0, 0, 0, 1);
    chk("lc_level", level, 1);
    chk("lc_phase", phase, 1);
    chk("lc_s3", secondsLeft, 3);

    // play timeout at level 1
    ticks(3);
    chk("l1_play", phase, 2);
    ticks(29);
    chk("to_s1", secondsLeft, 1);
    chk("to_still_play", phase, 2);
    ticks(1);
    chk("to_phase", phase, 5);
    chk("to_over", gameOver, 1);
    chk("to_gen", genEnable, 0);
    chk("to_secs", secondsLeft, 0);
    ticks(2);
    drive(0, 0, 0, 0, 1);
    chk("over_hold", phase, 5);
    chk("over_lvl", level, 1);
    drive(0, 1, 0, 0, 0);
    chk("restart_phase", phase, 1);
    chk("restart_lvl", level, 0);
    chk("restart_over", gameOver, 0);

    // all eight levels
    for (int lv = 0; lv < 8; lv++) begin
      ticks(3);
      chk("win_play", phase, 2);
      chk("win_lvl", level, lv);
      drive(0, 0, 0, 1, 0);
      chk("win_postsig", postSig, 1);
      drive(0, 0, 0, 0, 1);
    end
    chk("win_phase", phase, 4);
    chk("win_flag", gameWon, 1);
    chk("win_lvl7", level, 7);
    drive(0, 0, 0, 0, 1);
    chk("win_nowrap", level, 7);
    chk("win_hold", phase, 4);

    // answer coincident with expiring tick
    drive(0, 1, 0, 0, 0);
    chk("win_restart_lvl", level, 0);
    ticks(3);
    ticks(29);
    chk("co_s1", secondsLeft, 1);
    drive(1, 0, 0, 1, 0);
    chk("co_phase", phase, 3);
    chk("co_s10", secondsLeft, 10);

    // post-period handshake loss
    ticks(9);
    chk("pw_s1", secondsLeft, 1);
    chk("pw_phase", phase, 3);
    ticks(1);
    chk("pw_over", phase, 5);

    // abort beats answer
    drive(0, 1, 0, 0, 0);
    ticks(3);
    drive(0, 0, 1, 1, 0);
    chk("ab_phase", phase, 0);
    chk("ab_post", postSig, 0);
    chk("ab_gen", genEnable, 0);
    chk("ab_secs", secondsLeft, 0);

    // asynchronous reset mid-POST
    drive(0, 1, 0, 0, 0);
    ticks(3);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    ticks(3);
    drive(0, 0, 0, 1, 0);
    chk("ar_pre_phase", phase, 3);
    chk("ar_pre_lvl", level, 1);
    @(negedge Clk100M);
    #2;
    RstN = 1'b0;
    #1;
    chk("ar_phase", phase, 0);
    chk("ar_lvl", level, 0);
    chk("ar_secs", secondsLeft, 0);
    chk("ar_post", postSig, 0);
    @(negedge Clk100M);
    RstN = 1'b1;
    drive(0, 0, 0, 0, 1);
    chk("ar_lc_ign", phase, 0);
    chk("ar_lc_lvl", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Top-level round controller for the symbol-counting game. It sequences each level through a countdown, a play window, and a post period, and drives the start strobe of the post-period timer. It advances the level index on completion and ends the game on timeout or after the last level. It sits between the button/debounce logic and the symbol generator, post-period timer and 7-segment display mux, all on the 100 MHz domain.

## Interface
Parameters:
- PRE_SECONDS, 3, countdown length before each level (1..2^TIME_W-1)
- PLAY_SECONDS, 30, play window per level (1..2^TIME_W-1)
- POST_WAIT, 10, seconds allowed for levelComplete before fault (must exceed post-period length)
- NUM_LEVELS, 8, levels per game (2..2^LEVEL_W)
- LEVEL_W, 3, level index width
- TIME_W, 6, seconds counter width

Ports:
- Clk100M  in  1  system clock; one clock only
- RstN  in  1  asynchronous, active-low reset
- tick1Hz  in  1  one-cycle strobe per second, synchronous to Clk100M
- start  in  1  debounced one-cycle start/restart pulse
- abort  in  1  one-cycle pulse, returns to IDLE from any state
- answerCorrect  in  1  one-cycle pulse from answer checker
- levelComplete  in  1  one-cycle pulse from post-period timer
- genEnable  out  1  high throughout PLAY; enables symbol generation
- postSig  out  1  one-cycle pulse, first cycle of POST
- phase  out  3  current state encoding, for the display mux
- level  out  LEVEL_W  current level index, 0-based
- secondsLeft  out  TIME_W  remaining seconds in PRE/PLAY/POST; 0 otherwise
- gameOver  out  1  high in OVER
- gameWon  out  1  high in WIN

## Operation
- States: IDLE=0, PRE=1, PLAY=2, POST=3, WIN=4, OVER=5. All other codes are unreachable and recover to IDLE.
- IDLE: level=0. start -> PRE, secondsLeft loaded with PRE_SECONDS.
- PRE: each tick1Hz decrements secondsLeft. A tick while secondsLeft==1 -> PLAY, loading PLAY_SECONDS.
- PLAY: genEnable=1.
  - answerCorrect -> POST, loading POST_WAIT.
  - A tick while secondsLeft==1 with no answer -> OVER.
  - Other ticks decrement secondsLeft.
- POST:
  - levelComplete with level==NUM_LEVELS-1 -> WIN.
  - levelComplete otherwise -> level+1, then PRE with PRE_SECONDS.
  - A tick while secondsLeft==1 -> OVER (lost-handshake fault).
  - Other ticks decrement secondsLeft.
- WIN/OVER: outputs hold. start -> PRE with level=0.
- Priority, highest first: abort > answerCorrect/levelComplete > tick1Hz expiry > decrement.
- Ignored inputs:
  - start outside IDLE/WIN/OVER.
  - answerCorrect outside PLAY.
  - levelComplete outside POST.
- A tick1Hz coinciding with the transition into a state is not counted in the new state; the counter loads the full value.
- Level never wraps. The increment happens only on the non-final levelComplete path.

## Timing
- All outputs are registered. Event sampled at edge N -> new state and outputs visible after edge N.
- postSig is high for exactly the one cycle following the answerCorrect edge. It never repeats while in POST.
- genEnable drops on the same edge that enters POST or OVER.
- Reset values: phase=IDLE, level=0, secondsLeft=0, genEnable=0, postSig=0, gameOver=0, gameWon=0.
- Reset mid-operation clears immediately and asynchronously. The first state after release is IDLE regardless of inputs.
- PRE duration is exactly PRE_SECONDS ticks after entry. The PLAY timeout likewise occurs at the PLAY_SECONDS-th tick.

## Structure
- Shared package game_pkg holds:
  - the phase enum/constants (3-bit)
  - LEVEL_W and TIME_W defaults
- The post-period timer imports the same package.
- Sub-module sec_down_counter: a loadable TIME_W down-counter.
  - Inputs: load, loadVal, tick.
  - Outputs: count, expire (tick while count==1).
  - It is instantiated once and shared across PRE/PLAY/POST. The FSM issues load on every state entry.

## Test plan
- Reset, start, 3 ticks: PRE secondsLeft 3->2->1, then PLAY with secondsLeft=30 and genEnable=1 after the 3rd tick.
- answerCorrect in PLAY at secondsLeft=17: postSig one cycle, genEnable=0, phase=3, secondsLeft=10. Then levelComplete: level=1, phase=1, secondsLeft=3.
- 30 ticks in PLAY without an answer: phase=5 and gameOver=1 after the 30th tick. Further ticks and levelComplete cause no change. start -> PRE, level=0.
- Complete all 8 levels: after levelComplete at level=7, phase=4 and gameWon=1. level stays 7 and does not wrap.
- Simultaneous events:
  - answerCorrect with the expiring tick -> POST, not OVER.
  - abort with answerCorrect -> IDLE, and postSig stays 0.
- RstN asserted mid-POST: all outputs reset asynchronously before the next edge. A levelComplete after release is ignored.
